regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the core datapath, successor to the single-write 32x32 file. It has a configurable width, depth and number of read ports, and two write ports with fixed priority. Same-cycle write-to-read bypass replaces the negedge-write scheme. A per-register pending scoreboard supports the pipelined issue stage, and a sequential clear sweep after reset replaces the single-cycle array wipe.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_mp_if.sv | 37 +++
 rtl/regfile_init_ctrl.sv | 54 +++++
 rtl/regfile_mp.sv | 130 +++++++++++++
 tb/tb_regfile_mp.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the multi-port register file.
package regfile_pkg;

    // Default geometry: 32 registers of 32 bits.
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Clear-sweep controller states.
    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, two write ports, scoreboard alloc and ready.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) ();

    logic                     ready_o;
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        rd_pend_o;
    logic                     we0_i;
    logic [ADDR_W-1:0]        waddr0_i;
    logic [DATA_W-1:0]        wdata0_i;
    logic                     we1_i;
    logic [ADDR_W-1:0]        waddr1_i;
    logic [DATA_W-1:0]        wdata1_i;
    logic                     alloc_i;
    logic [ADDR_W-1:0]        alloc_addr_i;

    // Register-file side.
    modport slave (
        output ready_o, rd_data_o, rd_pend_o,
        input  rd_addr_i, we0_i, waddr0_i, wdata0_i,
        input  we1_i, waddr1_i, wdata1_i, alloc_i, alloc_addr_i
    );

    // Datapath / issue-stage side.
    modport master (
        input  ready_o, rd_data_o, rd_pend_o,
        output rd_addr_i, we0_i, waddr0_i, wdata0_i,
        output we1_i, waddr1_i, wdata1_i, alloc_i, alloc_addr_i
    );

endinterface : regfile_mp_if

// File: rtl/regfile_init_ctrl.sv
// Post-reset clear sweep: walks every address once, one per cycle, then reports ready.
module regfile_init_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_i,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // State and sweep counter; reset restarts the sweep from address 0.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: clear the current address, leave INIT after the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        case (state_q)
            RF_INIT: begin
                // The counter is being zeroed on a reset edge, so no clear then.
                clr_en = !rst_i;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = RF_RUN;
                end
            end
            RF_RUN: begin
                state_d = RF_RUN;
            end
            default: begin
                state_d = RF_INIT;
            end
        endcase
    end

    assign clr_addr = cnt_q;
    assign ready    = (state_q == RF_RUN);

endmodule : regfile_init_ctrl

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD combinational read
// ports with optional same-cycle bypass, and a per-register pending scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst_i,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;

    logic wr0_acc, wr1_acc, alloc_acc;
    logic wr0_zero, wr1_zero, alloc_zero;

    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pend;

    regfile_init_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_init (
        .clk      (clk),
        .rst_i    (rst_i),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    assign bus.ready_o = ready;

    // Register 0 is hard-wired when ZERO_REG is set: writes and allocs to it vanish.
    assign wr0_zero   = (ZERO_REG != 0) && (bus.waddr0_i == '0);
    assign wr1_zero   = (ZERO_REG != 0) && (bus.waddr1_i == '0);
    assign alloc_zero = (ZERO_REG != 0) && (bus.alloc_addr_i == '0);

    // Requests count only in RUN and never on a reset edge.
    assign wr0_acc   = ready && !rst_i && bus.we0_i   && !wr0_zero;
    assign wr1_acc   = ready && !rst_i && bus.we1_i   && !wr1_zero;
    assign alloc_acc = ready && !rst_i && bus.alloc_i && !alloc_zero;

    // Storage: sweep clears during INIT; in RUN port 1 is applied last so it wins a tie.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            regs_q[clr_addr] <= '0;
        end else begin
            if (wr0_acc) begin
                regs_q[bus.waddr0_i] <= bus.wdata0_i;
            end
            if (wr1_acc) begin
                regs_q[bus.waddr1_i] <= bus.wdata1_i;
            end
        end
    end

    // Scoreboard next state: writes retire a producer, an alloc (new producer) wins.
    always_comb begin
        pend_d = pend_q;
        if (wr0_acc) begin
            pend_d[bus.waddr0_i] = 1'b0;
        end
        if (wr1_acc) begin
            pend_d[bus.waddr1_i] = 1'b0;
        end
        if (alloc_acc) begin
            pend_d[bus.alloc_addr_i] = 1'b1;
        end
    end

    // Scoreboard register; reset clears every pending bit.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // One read port per iteration; all paths combinational from address and write inputs.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              ra_zero;
        logic              hit0, hit1;
        logic [DATA_W-1:0] rdata;
        logic              rpend;

        assign ra      = bus.rd_addr_i[gi*ADDR_W +: ADDR_W];
        assign ra_zero = (ZERO_REG != 0) && (ra == '0);
        assign hit0    = (BYPASS != 0) && wr0_acc && (bus.waddr0_i == ra);
        assign hit1    = (BYPASS != 0) && wr1_acc && (bus.waddr1_i == ra);

        // Read mux: zero register, then port 1 bypass, port 0 bypass, stored value.
        always_comb begin
            rdata = '0;
            rpend = 1'b0;
            if (ready) begin
                if (ra_zero) begin
                    rdata = '0;
                end else if (hit1) begin
                    rdata = bus.wdata1_i;
                end else if (hit0) begin
                    rdata = bus.wdata0_i;
                end else begin
                    rdata = regs_q[ra];
                end
                // A bypassed write has already delivered the value, so nothing is pending.
                rpend = pend_q[ra] && !hit0 && !hit1 && !ra_zero;
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = rdata;
        assign rd_pend[gi]                  = rpend;
    end

    assign bus.rd_data_o = rd_data;
    assign bus.rd_pend_o = rd_pend;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one BYPASS=1 and one BYPASS=0 instance on shared stimulus.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_i;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifb ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifn ();

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (ifb)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (ifn)
    );

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        al;
        logic [4:0]  aa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;   // bypass instance, port 0 data
        logic [31:0] ed1;   // bypass instance, port 1 data
        logic        ep0;   // bypass instance, port 0 pending
        logic        ep1;   // bypass instance, port 1 pending
        logic [31:0] en0;   // non-bypass instance, port 0 data
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic al, input logic [4:0] aa,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        ifb.we0_i = we0; ifb.waddr0_i = wa0; ifb.wdata0_i = wd0;
        ifb.we1_i = we1; ifb.waddr1_i = wa1; ifb.wdata1_i = wd1;
        ifb.alloc_i = al; ifb.alloc_addr_i = aa; ifb.rd_addr_i = {ra1, ra0};
        ifn.we0_i = we0; ifn.waddr0_i = wa0; ifn.wdata0_i = wd0;
        ifn.we1_i = we1; ifn.waddr1_i = wa1; ifn.wdata1_i = wd1;
        ifn.alloc_i = al; ifn.alloc_addr_i = aa; ifn.rd_addr_i = {ra1, ra0};
    endtask

    task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra0, ra1);
    endtask

    // Counts negedges with ready_o low (bounded); optionally attempts writes/allocs meanwhile.
    task automatic sweep_count(input int wr_cycles, output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifb.ready_o && ifn.ready_o) break;
            n++;
            chk($sformatf("init_quiet_b[%0d]", i), {ifb.rd_data_o[31:0], 1'b0},
                {31'd0, |{ifb.rd_data_o, ifb.rd_pend_o}});
            chk($sformatf("init_quiet_n[%0d]", i), {31'd0, |{ifn.rd_data_o, ifn.rd_pend_o}}, 32'd0);
            if (i < wr_cycles) begin
                drive(1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd20, 32'h2020_2020, 1'b1, 5'd4, 5'd3, 5'd20);
            end else begin
                idle(5'd3, 5'd20);
            end
        end
        $display("sweep: ready_o low for %0d cycles", n);
    endtask

    task automatic reset_and_sweep(input string tag);
        int n;
        rst_i = 1'b1;
        idle(5'd1, 5'd2);
        @(posedge clk); #1;
        chk({tag, "_rst_ready"}, {31'd0, ifb.ready_o}, 32'd0);
        chk({tag, "_rst_data"}, ifb.rd_data_o[31:0] | ifb.rd_data_o[63:32], 32'd0);
        chk({tag, "_rst_pend"}, {30'd0, ifb.rd_pend_o}, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        sweep_count(0, n);
        chk({tag, "_sweep_len"}, n, 32);
        @(posedge clk); #1;
        chk({tag, "_ready_high"}, {31'd0, ifb.ready_o}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            idle(5'(2 * i), 5'(2 * i + 1));
            #2;
            chk($sformatf("%s_b_r%0d", tag, 2 * i), ifb.rd_data_o[31:0], 32'd0);
            chk($sformatf("%s_b_r%0d", tag, 2 * i + 1), ifb.rd_data_o[63:32], 32'd0);
            chk($sformatf("%s_n_r%0d", tag, 2 * i), ifn.rd_data_o[31:0], 32'd0);
            chk($sformatf("%s_n_r%0d", tag, 2 * i + 1), ifn.rd_data_o[63:32], 32'd0);
            chk($sformatf("%s_pend%0d", tag, i), {28'd0, ifb.rd_pend_o, ifn.rd_pend_o}, 32'd0);
            @(posedge clk); #1;
        end
        $display("%s: all registers read back", tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        //          we0 wa0  wd0            we1 wa1  wd1           al aa    ra0   ra1   ed0            ed1            ep0 ep1 en0
        vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 5'd7, 32'h1111,     1'b1, 5'd7, 32'h2222, 1'b0, 5'd0,  5'd7,  5'd5,  32'h2222,     32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  5'd7,  5'd5,  32'h2222,     32'hDEADBEEF, 1'b0, 1'b0, 32'h2222};
        vt[4]  = '{1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd0, 32'h0,    1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        vt[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        vt[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd9,  5'd9,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  5'd9,  5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 32'h0};
        vt[8]  = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 32'h0,    1'b1, 5'd9,  5'd9,  5'd9,  32'h99,       32'h99,       1'b0, 1'b0, 32'h0};
        vt[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  5'd9,  5'd9,  32'h99,       32'h99,       1'b1, 1'b1, 32'h99};
        vt[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hAA,   1'b0, 5'd0,  5'd9,  5'd9,  32'hAA,       32'hAA,       1'b0, 1'b0, 32'h99};
        vt[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  5'd9,  5'd9,  32'hAA,       32'hAA,       1'b0, 1'b0, 32'hAA};
        vt[12] = '{1'b1, 5'd13, 32'h13,      1'b0, 5'd0, 32'h0,    1'b1, 5'd12, 5'd12, 5'd13, 32'h0,        32'h13,       1'b0, 1'b0, 32'h0};
        vt[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd13, 5'd12, 5'd13, 32'h0,        32'h13,       1'b1, 1'b0, 32'h0};
        vt[14] = '{1'b1, 5'd12, 32'h1212,    1'b1, 5'd13, 32'h1313, 1'b0, 5'd0, 5'd12, 5'd13, 32'h1212,     32'h1313,     1'b0, 1'b0, 32'h0};
        vt[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  5'd12, 5'd13, 32'h1212,     32'h1313,     1'b0, 1'b0, 32'h1212};

        // Power-up reset and first sweep.
        #1;
        reset_and_sweep("por");

        // Fill every register with junk, then reset: the sweep must wipe it all.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 5'(2 * i), 32'hA500_0000 | 32'(i), 1'b1, 5'(2 * i + 1), 32'h5A00_0000 | 32'(i),
                  1'b1, 5'(2 * i), 5'd0, 5'd0);
            @(posedge clk); #1;
        end
        reset_and_sweep("junk");
        check_all_zero("wipe");

        // Table: one vector per cycle, outputs compared before the clock edge.
        for (int v = 0; v < 16; v++) begin
            drive(vt[v].we0, vt[v].wa0, vt[v].wd0, vt[v].we1, vt[v].wa1, vt[v].wd1,
                  vt[v].al, vt[v].aa, vt[v].ra0, vt[v].ra1);
            #2;
            $display("vec %0d: ra=%0d/%0d d=%h/%h p=%b byp0=%h", v, vt[v].ra0, vt[v].ra1,
                     ifb.rd_data_o[31:0], ifb.rd_data_o[63:32], ifb.rd_pend_o, ifn.rd_data_o[31:0]);
            chk($sformatf("vec%0d_d0", v), ifb.rd_data_o[31:0], vt[v].ed0);
            chk($sformatf("vec%0d_d1", v), ifb.rd_data_o[63:32], vt[v].ed1);
            chk($sformatf("vec%0d_pend", v), {30'd0, ifb.rd_pend_o}, {30'd0, vt[v].ep1, vt[v].ep0});
            chk($sformatf("vec%0d_nobyp_d0", v), ifn.rd_data_o[31:0], vt[v].en0);
            @(posedge clk); #1;
        end
        idle(5'd0, 5'd0);

        // Reset pulsed at sweep address 10; writes/allocs attempted through the restarted sweep.
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_i = 1'b1;
        drive(1'b1, 5'd15, 32'hBAD0_BAD0, 1'b1, 5'd16, 32'hBAD1_BAD1, 1'b1, 5'd15, 5'd15, 5'd16);
        @(posedge clk); #1;
        rst_i = 1'b0;
        idle(5'd3, 5'd20);
        sweep_count(25, n);
        chk("restart_sweep_len", n, 32);
        @(posedge clk); #1;
        chk("restart_ready_high", {31'd0, ifb.ready_o}, 32'd1);
        check_all_zero("restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_regfile_mp
